// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture path.
//   state_e   : capture scheduler FSM encoding
//   N_CH_DEF  : default channel count, DW_DEF : default sample width
//   CH_W      : channel index width for the default channel count
//   idx_w()   : index width for an arbitrary channel count (at least 1 bit)
package scope_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StCapture,
        StSel,
        StRreq,
        StRlat,
        StHold,
        StFin
    } state_e;

    localparam int unsigned N_CH_DEF = 4;
    localparam int unsigned DW_DEF   = 8;
    localparam int unsigned CH_W     = $clog2(N_CH_DEF);

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lowest_bit_pick.sv
// Lowest-set-bit priority picker.
//   mask  in  N   candidate mask
//   idx   out W   index of the lowest set bit (0 when mask is empty)
//   found out 1   mask has at least one bit set
module lowest_bit_pick
    import scope_pkg::*;
#(
    parameter int unsigned N = N_CH_DEF,
    parameter int unsigned W = idx_w(N)
) (
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_capture_scheduler.sv
// Sequences the per-channel ADC capture drives: arms all enabled channels, waits for their
// end flags (with timeout), then drains each channel FIFO in ascending order onto a single
// valid/ready sample stream.
//   Clk, Reset_n          clock, asynchronous active-low reset
//   start, abort          capture request / unconditional return to idle
//   ch_en                 channel enable mask, sampled on an accepted start
//   adc_end, adc_empty    per-channel capture-complete and FIFO-empty flags
//   adc_q                 per-channel FIFO data, channel k at [k*DW +: DW]
//   adc_bg, adc_rdreq     per-channel capture level and FIFO read strobe
//   out_data/chan/valid/last, out_ready   sample stream to the host-link framer
//   busy, done, ch_timeout                status
module adc_capture_scheduler
    import scope_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned SAMPLES = 4096,
    parameter int unsigned TO_W    = 24,
    parameter int unsigned TIMEOUT = 10000000,
    parameter int unsigned ARM_CYC = 4,
    localparam int unsigned CW     = idx_w(N_CH)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [N_CH-1:0]    ch_en,
    input  logic [N_CH-1:0]    adc_end,
    input  logic [N_CH-1:0]    adc_empty,
    input  logic [N_CH*DW-1:0] adc_q,
    output logic [N_CH-1:0]    adc_bg,
    output logic [N_CH-1:0]    adc_rdreq,
    output logic [DW-1:0]      out_data,
    output logic [CW-1:0]      out_chan,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic [N_CH-1:0]    ch_timeout
);

    localparam int unsigned     WC_W     = $clog2(SAMPLES) + 1;
    localparam logic [WC_W-1:0] WC_MAX   = WC_W'(SAMPLES);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] ARM_LAST = TO_W'(ARM_CYC - 1);
    localparam logic [TO_W-1:0] TO_SAT   = '1;

    state_e            state_q, state_d;
    logic [N_CH-1:0]   en_q, en_d;
    logic [N_CH-1:0]   bg_q, bg_d;
    logic [N_CH-1:0]   tmo_q, tmo_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic [CW-1:0]     ch_q, ch_d;
    logic [DW-1:0]     data_q, data_d;
    logic [CW-1:0]     chan_q, chan_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    logic [DW-1:0]     q_lane [N_CH];
    logic [CW-1:0]     pick_idx;
    logic              pick_found;
    logic              all_end, to_hit, arm_done, rd_go;
    logic [WC_W-1:0]   wc_inc;

    always_comb begin
        for (int k = 0; k < int'(N_CH); k++) begin
            q_lane[k] = adc_q[k*DW +: DW];
        end
    end

    lowest_bit_pick #(
        .N (N_CH),
        .W (CW)
    ) u_pick (
        .mask  (en_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign all_end  = ((adc_end & en_q) == en_q);
    assign to_hit   = (to_q == TO_LAST);
    assign arm_done = (to_q == ARM_LAST);
    assign rd_go    = !adc_empty[ch_q] && (wc_q != WC_MAX);
    assign wc_inc   = wc_q + WC_W'(1);

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; abort overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StArm;
            StArm:     if (arm_done) state_d = StCapture;
            StCapture: if (all_end || to_hit) state_d = StSel;
            StSel:     state_d = pick_found ? StRreq : StFin;
            StRreq:    state_d = rd_go ? StRlat : StSel;
            StRlat:    state_d = StHold;
            StHold:    if (valid_q && out_ready) state_d = StRreq;
            StFin:     state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    // FSM outputs
    always_comb begin
        adc_rdreq = '0;
        if (state_q == StRreq && rd_go) adc_rdreq[ch_q] = 1'b1;
        busy = (state_q != StIdle);
        done = (state_q == StFin);
    end

    // Datapath next state
    always_comb begin
        en_d    = en_q;
        bg_d    = bg_q;
        tmo_d   = tmo_q;
        to_d    = to_q;
        wc_d    = wc_q;
        ch_d    = ch_q;
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    en_d  = ch_en;
                    tmo_d = '0;
                    to_d  = '0;
                end
            end
            StArm: begin
                // bg stays low here so each drive flushes its FIFO before capturing
                if (arm_done) begin
                    to_d = '0;
                    bg_d = en_q;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            StCapture: begin
                if (!all_end && to_hit) begin
                    tmo_d = tmo_q | (en_q & ~adc_end);
                    en_d  = en_q & adc_end;
                    bg_d  = en_q & adc_end;
                end else if (to_q != TO_SAT) begin
                    to_d = to_q + TO_W'(1);
                end
            end
            StSel: begin
                // bg is left alone: dropping it would flush the FIFO being drained
                if (pick_found) begin
                    ch_d           = pick_idx;
                    en_d[pick_idx] = 1'b0;
                    wc_d           = '0;
                end
            end
            StRlat: begin
                data_d  = q_lane[ch_q];
                chan_d  = ch_q;
                valid_d = 1'b1;
                wc_d    = wc_inc;
                // Empty here already reflects the read just issued, so this is a lookahead
                last_d  = (wc_inc == WC_MAX) || adc_empty[ch_q];
            end
            StHold: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            StFin: begin
                bg_d = '0;
            end
            default: ;
        endcase
        if (abort) begin
            bg_d    = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            en_q    <= '0;
            bg_q    <= '0;
            tmo_q   <= '0;
            to_q    <= '0;
            wc_q    <= '0;
            ch_q    <= '0;
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            en_q    <= en_d;
            bg_q    <= bg_d;
            tmo_q   <= tmo_d;
            to_q    <= to_d;
            wc_q    <= wc_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign adc_bg     = bg_q;
    assign out_data   = data_q;
    assign out_chan   = chan_q;
    assign out_valid  = valid_q;
    assign out_last   = last_q;
    assign ch_timeout = tmo_q;

endmodule
